// File: rtl/alu_op_issuer.sv
// Issues one command at a time to the four-unit ALU and returns the selected
// unit's result on a valid/ready response port. A flag timeout turns a missing result into an error response.
//
// state  | meaning
// IDLE   | req_ready high, waiting for a command
// SETTLE | operands driven, waiting out ALU latency (flags ignored)
// SAMPLE | watching the selected unit flag, timeout counter running
// RESP   | response held on rsp_* until rsp_ready
module alu_op_issuer #(
   parameter int in_width      = 16,
   parameter int out_width     = 16,
   parameter int CMP_out_width = 2,
   parameter int ALU_LAT       = 1,
   parameter int TIMEOUT       = 8
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic [3:0]               req_fun,
   input  logic [in_width-1:0]      req_a,
   input  logic [in_width-1:0]      req_b,
   output logic [in_width-1:0]      A,
   output logic [in_width-1:0]      B,
   output logic [3:0]               ALU_FUN,
   input  logic [out_width-1:0]     arith_out,
   input  logic [out_width-1:0]     logic_out,
   input  logic [out_width-1:0]     shift_out,
   input  logic [CMP_out_width-1:0] CMP_out,
   input  logic                     arith_flag,
   input  logic                     logic_flag,
   input  logic                     CMP_flag,
   input  logic                     shift_flag,
   input  logic                     carry_out,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [out_width-1:0]     rsp_data,
   output logic [1:0]               rsp_unit,
   output logic                     rsp_carry,
   output logic                     rsp_err
);

   localparam int SW = (ALU_LAT < 2) ? 1 : $clog2(ALU_LAT + 1);
   localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      SAMPLE = 2'd2,
      RESP   = 2'd3
   } state_t;

   state_t            state;
   logic [SW-1:0]     settle_cnt;
   logic [TW-1:0]     timeout_cnt;

   logic                 sel_flag;
   logic [out_width-1:0] sel_data;
   logic                 sel_carry;

   // Only the unit named by the latched function is ever looked at.
   always_comb begin
      sel_flag  = 1'b0;
      sel_data  = '0;
      sel_carry = 1'b0;
      case (ALU_FUN[3:2])
         2'b00: begin
            sel_flag  = arith_flag;
            sel_data  = arith_out;
            sel_carry = carry_out;
         end
         2'b01: begin
            sel_flag = logic_flag;
            sel_data = logic_out;
         end
         2'b10: begin
            sel_flag = CMP_flag;
            sel_data = {{(out_width-CMP_out_width){1'b0}}, CMP_out};
         end
         default: begin
            sel_flag = shift_flag;
            sel_data = shift_out;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         state       <= IDLE;
         settle_cnt  <= '0;
         timeout_cnt <= '0;
         req_ready   <= 1'b1;
         A           <= '0;
         B           <= '0;
         ALU_FUN     <= '0;
         rsp_valid   <= 1'b0;
         rsp_data    <= '0;
         rsp_unit    <= '0;
         rsp_carry   <= 1'b0;
         rsp_err     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  A          <= req_a;
                  B          <= req_b;
                  ALU_FUN    <= req_fun;
                  settle_cnt <= SW'(ALU_LAT);
                  req_ready  <= 1'b0;
                  state      <= SETTLE;
               end
            end
            SETTLE: begin
               settle_cnt <= settle_cnt - 1'b1;
               if (settle_cnt == SW'(1)) begin
                  timeout_cnt <= '0;
                  state       <= SAMPLE;
               end
            end
            SAMPLE: begin
               // A flag arriving on the last allowed cycle still beats the timeout.
               if (sel_flag) begin
                  rsp_data  <= sel_data;
                  rsp_unit  <= ALU_FUN[3:2];
                  rsp_carry <= sel_carry;
                  rsp_err   <= 1'b0;
                  rsp_valid <= 1'b1;
                  state     <= RESP;
               end else if (timeout_cnt == TW'(TIMEOUT)) begin
                  rsp_data  <= '0;
                  rsp_unit  <= ALU_FUN[3:2];
                  rsp_carry <= 1'b0;
                  rsp_err   <= 1'b1;
                  rsp_valid <= 1'b1;
                  state     <= RESP;
               end else begin
                  timeout_cnt <= timeout_cnt + 1'b1;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  req_ready <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_op_issuer.sv
// Directed bench for alu_op_issuer; the ALU is modelled by hand-driven
// result/flag signals with ALU_LAT = 1.
module tb_alu_op_issuer;

   logic        CLK = 1'b0;
   logic        RST;
   logic        req_valid;
   logic        req_ready;
   logic [3:0]  req_fun;
   logic [15:0] req_a, req_b;
   logic [15:0] A, B;
   logic [3:0]  ALU_FUN;
   logic [15:0] arith_out, logic_out, shift_out;
   logic [1:0]  CMP_out;
   logic        arith_flag, logic_flag, CMP_flag, shift_flag, carry_out;
   logic        rsp_valid, rsp_ready;
   logic [15:0] rsp_data;
   logic [1:0]  rsp_unit;
   logic        rsp_carry, rsp_err;

   int checks = 0;
   int failures = 0;

   alu_op_issuer #(
      .in_width(16), .out_width(16), .CMP_out_width(2), .ALU_LAT(1), .TIMEOUT(8)
   ) dut (
      .CLK(CLK), .RST(RST),
      .req_valid(req_valid), .req_ready(req_ready), .req_fun(req_fun),
      .req_a(req_a), .req_b(req_b),
      .A(A), .B(B), .ALU_FUN(ALU_FUN),
      .arith_out(arith_out), .logic_out(logic_out), .shift_out(shift_out),
      .CMP_out(CMP_out),
      .arith_flag(arith_flag), .logic_flag(logic_flag), .CMP_flag(CMP_flag),
      .shift_flag(shift_flag), .carry_out(carry_out),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_unit(rsp_unit), .rsp_carry(rsp_carry), .rsp_err(rsp_err)
   );

   always #5 CLK = ~CLK;

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [3:0] fun, input logic [15:0] a, input logic [15:0] b);
      req_valid = 1'b1;
      req_fun   = fun;
      req_a     = a;
      req_b     = b;
      step();
      req_valid = 1'b0;
   endtask

   logic seen_rsp;

   initial begin
      RST = 1'b0; req_valid = 1'b0; req_fun = '0; req_a = '0; req_b = '0;
      arith_out = '0; logic_out = '0; shift_out = '0; CMP_out = '0;
      arith_flag = 0; logic_flag = 0; CMP_flag = 0; shift_flag = 0; carry_out = 0;
      rsp_ready = 1'b0;
      step(); step();
      chk("rst_A", A, 0);
      chk("rst_fun", ALU_FUN, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_data", rsp_data, 0);
      chk("rst_req_ready", req_ready, 1);
      RST = 1'b1;
      step();

      // arith with flag present: operands at cycle 1, response at cycle 3
      arith_out = 16'h1234; carry_out = 1'b1;
      send(4'b0000, 16'h0003, 16'h0004);
      chk("t1_fun", ALU_FUN, 4'b0000);
      chk("t1_A", A, 16'h0003);
      chk("t1_B", B, 16'h0004);
      chk("t1_req_ready_busy", req_ready, 0);
      arith_flag = 1'b1;
      step();
      chk("t1_valid_c2", rsp_valid, 0);
      step();
      chk("t1_valid_c3", rsp_valid, 1);
      chk("t1_data", rsp_data, 16'h1234);
      chk("t1_unit", rsp_unit, 2'b00);
      chk("t1_carry", rsp_carry, 1);
      chk("t1_err", rsp_err, 0);
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      chk("t1_idle_valid", rsp_valid, 0);
      chk("t1_idle_ready", req_ready, 1);
      chk("t1_A_hold", A, 16'h0003);
      arith_flag = 1'b0;

      // compare: zero-extended, carry masked
      CMP_out = 2'b10; CMP_flag = 1'b1;
      send(4'b1001, 16'h0005, 16'h0006);
      step(); step();
      chk("t2_valid", rsp_valid, 1);
      chk("t2_data", rsp_data, 16'h0002);
      chk("t2_unit", rsp_unit, 2'b10);
      chk("t2_carry", rsp_carry, 0);
      rsp_ready = 1'b1; step(); rsp_ready = 1'b0;
      CMP_flag = 1'b0;

      // shift with no flag, unrelated logic flag high: error at cycle 11
      shift_out = 16'hBEEF; logic_flag = 1'b1;
      send(4'b1100, 16'h0001, 16'h0002);
      for (int i = 2; i <= 10; i++) step();
      chk("t3_valid_c10", rsp_valid, 0);
      step();
      chk("t3_valid_c11", rsp_valid, 1);
      chk("t3_err", rsp_err, 1);
      chk("t3_data", rsp_data, 16'h0000);
      chk("t3_unit", rsp_unit, 2'b11);
      chk("t3_carry", rsp_carry, 0);
      rsp_ready = 1'b1; step(); rsp_ready = 1'b0;
      logic_flag = 1'b0;

      // stale arith flag during settle, new result one cycle late
      arith_out = 16'h5555; carry_out = 1'b0; arith_flag = 1'b1;
      send(4'b0000, 16'h0011, 16'h0022);
      step();
      arith_flag = 1'b0;
      step();
      chk("t4_valid_c3", rsp_valid, 0);
      arith_flag = 1'b1; arith_out = 16'h9999;
      step();
      chk("t4_valid_c4", rsp_valid, 1);
      chk("t4_data", rsp_data, 16'h9999);
      arith_flag = 1'b0; arith_out = 16'h0000;

      // backpressure with a second command pending
      req_valid = 1'b1; req_fun = 4'b0100; req_a = 16'h0007; req_b = 16'h0008;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("t5_req_ready", req_ready, 0);
         chk("t5_valid", rsp_valid, 1);
         chk("t5_data", rsp_data, 16'h9999);
         chk("t5_A_hold", A, 16'h0011);
      end
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      chk("t5_idle_ready", req_ready, 1);
      chk("t5_idle_A", A, 16'h0011);
      step();
      req_valid = 1'b0;
      chk("t5_accept_ready", req_ready, 0);
      chk("t5_accept_A", A, 16'h0007);
      chk("t5_accept_fun", ALU_FUN, 4'b0100);
      logic_out = 16'h0F0F; logic_flag = 1'b1;
      step(); step();
      chk("t5_second_valid", rsp_valid, 1);
      chk("t5_second_data", rsp_data, 16'h0F0F);
      chk("t5_second_unit", rsp_unit, 2'b01);
      rsp_ready = 1'b1; step(); rsp_ready = 1'b0;
      logic_flag = 1'b0;

      // reset during settle drops the command
      arith_out = 16'h1111; arith_flag = 1'b1; carry_out = 1'b1;
      send(4'b0000, 16'h000A, 16'h000B);
      RST = 1'b0;
      step();
      RST = 1'b1;
      chk("t6_A", A, 0);
      chk("t6_B", B, 0);
      chk("t6_fun", ALU_FUN, 0);
      chk("t6_valid", rsp_valid, 0);
      chk("t6_data", rsp_data, 0);
      chk("t6_unit", rsp_unit, 0);
      chk("t6_err", rsp_err, 0);
      chk("t6_req_ready", req_ready, 1);
      rsp_ready = 1'b1;
      seen_rsp = 1'b0;
      for (int i = 0; i < 6; i++) begin
         step();
         if (rsp_valid) seen_rsp = 1'b1;
      end
      chk("t6_no_rsp", seen_rsp, 0);
      chk("t6_ready_after", req_ready, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/alu_op_issuer.md
# alu_op_issuer

Front-end controller that drives the team's four-unit ALU (arithmetic, logic, compare, shift) from a valid/ready command stream. Each accepted command is latched onto the ALU operand and function inputs. The block then waits the ALU's registered latency and checks that the selected unit raised its flag. It returns the selected unit's result, zero-extended, on a valid/ready response port. A flag timeout converts a missing ALU response into an error response, so the issuer never hangs.

## Interface
- in_width, 16, operand width (A, B)
- out_width, 16, arith/logic/shift result width and rsp_data width
- CMP_out_width, 2, compare result width; zero-extended into rsp_data
- ALU_LAT, 1, clock edges from ALU input change to valid registered ALU output (≥1)
- TIMEOUT, 8, cycles the selected flag may stay low after the sample point before an error is reported (≥1)

Ports:
- CLK  in  1  single clock; everything on the rising edge
- RST  in  1  synchronous, active-low reset
- req_valid  in  1  command valid
- req_ready  out  1  command accepted when req_valid & req_ready
- req_fun  in  4  ALU function; [3:2] unit select (00 arith, 01 logic, 10 CMP, 11 shift), [1:0] op
- req_a, req_b  in  in_width  operands
- A, B  out  in_width  registered operands to ALU
- ALU_FUN  out  4  registered function to ALU
- arith_out, logic_out, shift_out  in  out_width  ALU results
- CMP_out  in  CMP_out_width  compare result
- arith_flag, logic_flag, CMP_flag, shift_flag  in  1  ALU unit-valid flags
- carry_out  in  1  arithmetic carry
- rsp_valid  out  1  response valid; held until rsp_ready
- rsp_ready  in  1  response consumed when rsp_valid & rsp_ready
- rsp_data  out  out_width  selected result
- rsp_unit  out  2  unit that produced rsp_data (copy of ALU_FUN[3:2])
- rsp_carry  out  1  carry_out for arith; 0 for other units
- rsp_err  out  1  1 = selected flag never seen (timeout); rsp_data = 0

## Operation
States: IDLE, SETTLE, SAMPLE, RESP.

- **IDLE**
  - req_ready = 1, and only in IDLE.
  - On handshake: A, B and ALU_FUN load req_a, req_b and req_fun; go to SETTLE with settle counter = ALU_LAT.
- **SETTLE**
  - Counter decrements each cycle; at 0 go to SAMPLE with timeout counter = 0.
  - ALU flags are ignored here, so a flag left over from the previous command is never taken.
- **SAMPLE**
  - The selected flag is chosen by ALU_FUN[3:2].
  - Flag high: capture the result into rsp_data, rsp_unit and rsp_carry, set rsp_err = 0, go to RESP.
    - Arith result: arith_out, with carry_out into rsp_carry.
    - Logic result: logic_out.
    - CMP result: {zeros, CMP_out}.
    - Shift result: shift_out.
  - Flag low: increment the timeout counter. When it reaches TIMEOUT, set rsp_err = 1 and rsp_data = 0, go to RESP.
  - Flags of unselected units are ignored.
- **RESP**
  - rsp_valid = 1; rsp_data, rsp_unit, rsp_carry and rsp_err are stable while rsp_valid = 1.
  - On rsp_ready, go to IDLE.
- A, B and ALU_FUN hold their value until the next accepted command, not just until the response.
- Reset, in any state:
  - State returns to IDLE.
  - A, B, ALU_FUN, rsp_data, rsp_unit, rsp_carry and rsp_err are all 0; rsp_valid = 0.
  - req_ready = 1 from the first cycle after reset deasserts.
  - An in-flight command is dropped and produces no response.

## Timing
- Cycle 0: request handshake.
- Cycles 1..ALU_LAT: SETTLE.
- Cycle ALU_LAT+1: first SAMPLE.
- Flag-present case: rsp_valid rises at cycle ALU_LAT+2 (cycle 3 for the default ALU_LAT = 1).
- Timeout case: rsp_valid rises at cycle ALU_LAT+TIMEOUT+2.
- Throughput: at most one command per ALU_LAT+3 cycles with rsp_ready tied high; req_ready returns in the cycle after the response handshake.
- Simultaneous events:
  - In RESP, a response handshake and a waiting req_valid are not overlapped; the request is accepted the next cycle.
  - In SAMPLE, if the flag rises in the same cycle the counter would hit TIMEOUT, the flag wins (no error).
- Width rule: CMP_out_width < out_width; upper bits of rsp_data are 0 for CMP results.

## Test plan
Use an ALU stub with latency ALU_LAT = 1.

1. **Arith, flag present.** req_fun = 0000, A = 0x0003, B = 0x0004; stub returns arith_out = 0x1234, carry_out = 1, arith_flag = 1.
   - Required: ALU_FUN = 0000 and A/B driven at cycle 1.
   - Required: rsp_valid at cycle 3 with rsp_data = 0x1234, rsp_unit = 00, rsp_carry = 1, rsp_err = 0.
2. **CMP zero-extend and carry masking.** req_fun = 1001; stub CMP_out = 2'b10, CMP_flag = 1, carry_out = 1.
   - Required: rsp_data = 0x0002, rsp_unit = 10, rsp_carry = 0.
3. **Timeout.** req_fun = 1100; stub holds shift_flag = 0 but logic_flag = 1.
   - Required: rsp_valid at cycle 11 (TIMEOUT = 8) with rsp_err = 1, rsp_data = 0x0000.
4. **Stale-flag rejection.** arith_flag is already high before the request; stub delays the new result by one extra cycle.
   - Required: the response carries the new value, not the stale one.
5. **Backpressure.** Hold rsp_ready = 0 for 5 cycles with a second req_valid pending.
   - Required: req_ready = 0 and the response fields are stable throughout.
   - Required: the second command is accepted one cycle after the rsp_ready handshake.
6. **Reset mid-operation.** Drive RST = 0 for one cycle during SETTLE.
   - Required: all outputs are 0 next cycle, no response is ever produced, and req_ready = 1.
